next_block_queue: RTL
=====================

// Module: next_block_queue
// PURPOSE
// - Prefetch queue between the random block generator and the game FSM.
// - Pulses the generator enable, waits out the generator pipeline, then captures the new block into a DEPTH-entry FIFO.
// - Presents the FIFO head as the block to spawn and entry 1 as the "next" preview, so a spawn never stalls on generator latency.
// PARAMETERS
// - DEPTH    3  queue entries; >= 2.
// - GEN_LAT  3  cycles from the end of a gen_en_o pulse until the generator output is stable; >= 2.
// PORTS
// - clk_i                 in   1       system clock
// - rst_n_i               in   1       asynchronous active-low reset
// - gen_en_o              out  1       one-cycle advance pulse to the generator
// - gen_block_i_data      in   64      4 rotations x 16-bit bitmap
// - gen_block_i_color     in   `TETRIS_COLORS_WIDTH    block color, 1..7
// - gen_block_i_rotation  in   2       initial rotation
// - gen_block_i_x         in   `FIELD_COL_CNT_WIDTH+1  signed spawn column
// - gen_block_i_y         in   `FIELD_ROW_CNT_WIDTH+1  signed spawn row
// - flush_i               in   1       synchronous clear; used on new game
// - pop_i                 in   1       game FSM consumes the head
// - head_valid_o          out  1       head entry valid (count >= 1)
// - head_block_o_data / _color / _rotation / _x / _y   out  as gen_block_i_*   entry 0
// - preview_valid_o       out  1       count >= 2
// - preview_o_data        out  64      entry 1 bitmap
// - preview_o_color       out  `TETRIS_COLORS_WIDTH    entry 1 color
// - count_o               out  $clog2(DEPTH+1)        occupied entries
// BEHAVIOUR
// - Reset: all outputs are 0, all entries are 0, count = 0, FSM = IDLE, wait counter = 0.
// - Outputs are driven directly from the entry registers and count. No extra output register.
// - FSM (Moore):
//   - IDLE: go to ADVANCE when count < DEPTH.
//   - ADVANCE: gen_en_o = 1 for exactly this cycle. Load wcnt = GEN_LAT-1. Go to WAIT.
//   - WAIT: decrement wcnt. When wcnt == 0, go to CAPTURE.
//   - CAPTURE: on the leaving edge, write all gen_block_i_* fields into slot count (or count-1 if popping); count += 1. Go to IDLE.
// - Only one generate is in flight at a time. A refill starts only when count < DEPTH. A pop can only lower count, so CAPTURE always has a free slot.
// - Refill period is GEN_LAT+3 cycles per entry.
//   - After reset release: head_valid_o is high after edge 6.
//   - The queue is full after edge 6*DEPTH (GEN_LAT=3).
// - pop_i with head_valid_o = 1: entries shift down by one (entry k <= entry k+1); the top slot is zeroed; count -= 1.
// - pop_i with count == 0: ignored; no state change.
// - pop_i together with a CAPTURE write: shift first, then write the new block into slot count-1; count is unchanged.
// - flush_i: count = 0 and all entries are zeroed on the next edge; FSM = IDLE; gen_en_o = 0.
//   - Any in-flight capture is abandoned.
//   - flush_i has priority over pop_i and CAPTURE.
//   - Refill resumes the cycle after flush_i deasserts.
// - Async reset mid-refill: immediate return to the reset state. Partial generator output is never captured.
// - Captured fields are stored bit-exact. x/y are sign-preserved; no arithmetic is applied.
// TESTING
// - Reset, then run 18 cycles with a generator model (GEN_LAT=3):
//   - gen_en_o pulses at cycles 1, 7, 13.
//   - head_valid_o rises after edge 6; count_o = 3 after edge 18.
//   - No further gen_en_o pulses while the queue is full.
// - Full queue holding colors A, B, C; pulse pop_i:
//   - Next cycle: head color = B, preview color = C, count_o = 2.
//   - gen_en_o pulses one cycle later; count_o = 3 after 6 edges.
// - pop_i held high from reset with the queue empty:
//   - count_o stays 0 until the first CAPTURE.
//   - Each CAPTURE is consumed immediately.
//   - head_valid_o glitch-free high for one cycle per entry.
// - count = 2 with pop_i asserted in the CAPTURE cycle: count_o stays 2; the new block appears at entry 1 (preview_o_*).
// - flush_i asserted mid-WAIT: next cycle count_o = 0 and head_valid_o = 0. The stale generator output is not captured; the refill restarts cleanly.
// - Assert rst_n_i low mid-WAIT for 1 cycle: outputs go to 0 asynchronously; fill timing after release matches the first scenario.
// - Every captured head satisfies color in 1..7, data equal to the bitmap for that color, x = 4, y = 0.

Source files
------------

// File: rtl/next_block_queue.sv
// Prefetch queue between the random block generator and the game FSM.
// Pulses the generator, waits out its pipeline, then captures the block into a DEPTH-entry FIFO.
`ifndef TETRIS_COLORS_WIDTH
`define TETRIS_COLORS_WIDTH 3
`endif
`ifndef FIELD_COL_CNT_WIDTH
`define FIELD_COL_CNT_WIDTH 4
`endif
`ifndef FIELD_ROW_CNT_WIDTH
`define FIELD_ROW_CNT_WIDTH 5
`endif

module next_block_queue #(
  parameter int DEPTH   = 3,
  parameter int GEN_LAT = 3
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  output logic                                  gen_en_o,
  input  logic [63:0]                           gen_block_i_data,
  input  logic [`TETRIS_COLORS_WIDTH-1:0]       gen_block_i_color,
  input  logic [1:0]                            gen_block_i_rotation,
  input  logic signed [`FIELD_COL_CNT_WIDTH:0]  gen_block_i_x,
  input  logic signed [`FIELD_ROW_CNT_WIDTH:0]  gen_block_i_y,
  input  logic                                  flush_i,
  input  logic                                  pop_i,
  output logic                                  head_valid_o,
  output logic [63:0]                           head_block_o_data,
  output logic [`TETRIS_COLORS_WIDTH-1:0]       head_block_o_color,
  output logic [1:0]                            head_block_o_rotation,
  output logic signed [`FIELD_COL_CNT_WIDTH:0]  head_block_o_x,
  output logic signed [`FIELD_ROW_CNT_WIDTH:0]  head_block_o_y,
  output logic                                  preview_valid_o,
  output logic [63:0]                           preview_o_data,
  output logic [`TETRIS_COLORS_WIDTH-1:0]       preview_o_color,
  output logic [$clog2(DEPTH+1)-1:0]            count_o
);

  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int WCNT_W = $clog2(GEN_LAT);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef struct packed {
    logic [63:0]                          data;
    logic [`TETRIS_COLORS_WIDTH-1:0]      color;
    logic [1:0]                           rotation;
    logic [`FIELD_COL_CNT_WIDTH:0]        x;
    logic [`FIELD_ROW_CNT_WIDTH:0]        y;
  } block_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADVANCE = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [WCNT_W-1:0]   wcnt_r, wcnt_s;
  logic [CNT_W-1:0]    count_r, count_s;
  block_t              entry_r [DEPTH];
  block_t              entry_s [DEPTH];
  block_t              gen_blk_s;

  assign gen_blk_s = '{data: gen_block_i_data, color: gen_block_i_color,
                       rotation: gen_block_i_rotation, x: gen_block_i_x, y: gen_block_i_y};

  // Refill sequencer: one generate in flight, restarted only when a slot is free.
  always_comb begin
    state_s = state_r;
    wcnt_s  = wcnt_r;
    if (flush_i) begin
      state_s = ST_IDLE;
      wcnt_s  = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (count_r < DEPTH_C) state_s = ST_ADVANCE;
          else                   state_s = ST_IDLE;
        end
        ST_ADVANCE: begin
          state_s = ST_WAIT;
          wcnt_s  = WCNT_W'(GEN_LAT-1);
        end
        ST_WAIT: begin
          if (wcnt_r == '0) begin
            state_s = ST_CAPTURE;
          end else begin
            state_s = ST_WAIT;
            wcnt_s  = wcnt_r - 1'b1;
          end
        end
        ST_CAPTURE: state_s = ST_IDLE;
        default:    state_s = ST_IDLE;
      endcase
    end
  end

  // Queue update: flush beats everything; a pop shifts before the capture lands in the freed slot.
  always_comb begin
    entry_s = entry_r;
    count_s = count_r;
    if (flush_i) begin
      for (int k = 0; k < DEPTH; k++) entry_s[k] = '0;
      count_s = '0;
    end else begin
      if (pop_i && (count_r != '0)) begin
        for (int k = 0; k < DEPTH-1; k++) entry_s[k] = entry_r[k+1];
        entry_s[DEPTH-1] = '0;
        count_s = count_r - 1'b1;
      end else begin
        count_s = count_r;
      end
      if (state_r == ST_CAPTURE) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (CNT_W'(k) == count_s) entry_s[k] = gen_blk_s;
          else                      entry_s[k] = entry_s[k];
        end
        count_s = count_s + 1'b1;
      end else begin
        count_s = count_s;
      end
    end
  end

  // State, wait counter, occupancy and entry storage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
      wcnt_r  <= '0;
      count_r <= '0;
      for (int k = 0; k < DEPTH; k++) entry_r[k] <= '0;
    end else begin
      state_r <= state_s;
      wcnt_r  <= wcnt_s;
      count_r <= count_s;
      entry_r <= entry_s;
    end
  end

  assign gen_en_o              = (state_r == ST_ADVANCE);
  assign head_valid_o          = (count_r != '0);
  assign preview_valid_o       = (count_r >= CNT_W'(2));
  assign head_block_o_data     = entry_r[0].data;
  assign head_block_o_color    = entry_r[0].color;
  assign head_block_o_rotation = entry_r[0].rotation;
  assign head_block_o_x        = entry_r[0].x;
  assign head_block_o_y        = entry_r[0].y;
  assign preview_o_data        = entry_r[1].data;
  assign preview_o_color       = entry_r[1].color;
  assign count_o               = count_r;

endmodule
